// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares a single-port, 1-cycle-latency video RAM between the display fetch
// path and the CPU bus. The display owns the RAM whenever it asks, except
// when a CPU request has been held off for MAX_WAIT cycles. Then one CPU slot
// is forced and the display is told it missed that fetch.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   disp_req/disp_addr            display fetch request and halfword address
//   disp_data/disp_valid/disp_miss fetch result, one cycle after the request
//   cpu_req/we/addr/wdata/be      CPU access, held until cpu_ready
//   cpu_ready/cpu_rdata           completion pulse and read data
//   mem_addr/we/be/wdata/rdata    VRAM macro interface
module vram_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [15:0]       disp_data,
    output logic              disp_valid,
    output logic              disp_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    input  logic [1:0]        cpu_be,
    output logic              cpu_ready,
    output logic [15:0]       cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata
);

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_DISP = 2'd1,
        G_CPU  = 2'd2
    } grant_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    grant_t      grant;
    grant_t      grant_q;
    logic        inflight;
    logic [7:0]  wait_cnt;
    logic        miss_q;
    logic        rd_q;
    logic [15:0] disp_hold;
    logic [15:0] rdata_hold;
    logic        cpu_elig;
    logic        force_slot;

    // Grant for the current cycle. Reset suppresses every grant, so the RAM
    // never sees a write strobe while rst is high.
    always_comb begin
        cpu_elig   = cpu_req & ~inflight;
        force_slot = cpu_elig & (wait_cnt == MAX_WAIT_C);
        grant      = G_NONE;
        if (!rst) begin
            if (force_slot || (cpu_elig && !disp_req))
                grant = G_CPU;
            else if (disp_req)
                grant = G_DISP;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = 2'b00;
        mem_wdata = '0;
        case (grant)
            G_DISP: begin
                mem_addr = disp_addr;
                mem_be   = 2'b11;
            end
            G_CPU: begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_be    = cpu_be;
                mem_wdata = cpu_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q    <= G_NONE;
            inflight   <= 1'b0;
            wait_cnt   <= '0;
            miss_q     <= 1'b0;
            rd_q       <= 1'b0;
            disp_hold  <= '0;
            rdata_hold <= '0;
        end else begin
            grant_q <= grant;
            miss_q  <= disp_req && (grant == G_CPU);
            rd_q    <= (grant == G_CPU) && !cpu_we;

            // inflight covers the ready cycle, which blocks a re-grant there.
            if (grant == G_CPU)
                inflight <= 1'b1;
            else if (grant_q == G_CPU)
                inflight <= 1'b0;

            if (grant == G_CPU || !cpu_req)
                wait_cnt <= '0;
            else if (cpu_elig && grant == G_DISP && wait_cnt != MAX_WAIT_C)
                wait_cnt <= wait_cnt + 8'd1;

            // The RAM output is only live in the cycle after the access, so
            // the hold registers keep the value for the following cycles.
            if (grant_q == G_DISP)
                disp_hold <= mem_rdata;
            if (grant_q == G_CPU && rd_q)
                rdata_hold <= mem_rdata;
        end
    end

    // Completions are gated by rst so an access caught by reset is abandoned.
    assign disp_valid = (grant_q == G_DISP) && !rst;
    assign disp_miss  = miss_q && !rst;
    assign cpu_ready  = (grant_q == G_CPU) && !rst;
    assign disp_data  = disp_valid ? mem_rdata : disp_hold;
    assign cpu_rdata  = (cpu_ready && rd_q) ? mem_rdata : rdata_hold;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
    localparam int AW = 16;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [15:0]   disp_data;
    logic          disp_valid, disp_miss;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [15:0]   cpu_wdata = '0;
    logic [1:0]    cpu_be = 2'b00;
    logic          cpu_ready;
    logic [15:0]   cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [1:0]    mem_be;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
        .disp_valid(disp_valid), .disp_miss(disp_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // VRAM macro: synchronous read, byte-enabled write, word i starts as i.
    logic [15:0] vram [0:65535];
    logic        vram_init = 1'b0;
    always @(posedge clk) begin
        if (!vram_init) begin
            for (int i = 0; i < 65536; i++) vram[i] <= 16'(i);
            vram_init <= 1'b1;
        end else if (mem_we) begin
            if (mem_be[1]) vram[mem_addr][15:8] <= mem_wdata[15:8];
            if (mem_be[0]) vram[mem_addr][7:0]  <= mem_wdata[7:0];
        end
        mem_rdata <= vram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit miss; logic [15:0] data; } drec_t;
    typedef struct { int cyc; bit we;   logic [15:0] data; } crec_t;
    drec_t dq[$];
    crec_t cq[$];

    // Reference model state
    logic [15:0]   ref_mem [0:65535];
    int            m_wait = 0;
    bit            m_infl = 0, m_gc = 0, m_rdy = 0;
    bit            pd_v = 0, pd_miss = 0, pc_v = 0, pc_we = 0;
    logic [15:0]   pd_data = '0, pc_data = '0;
    logic [15:0]   last_disp = '0, last_rd = '0;
    int            exp_kind = 0;
    bit            exp_we = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [1:0]    exp_be = '0;
    logic [15:0]   exp_wdata = '0;

    // Checker control (written by the driver only)
    bit    chk_idle = 0, chk_win_go = 0, chk_end = 0;
    int    chk_win_act = 0, chk_win_exp = 0;
    string chk_win_name = "";

    // Counters (written by the monitor only)
    int checks = 0, errors = 0, rdy_count = 0, miss_count = 0;

    // One cycle of the arbitration rules applied to the current inputs.
    task automatic model_cycle();
        drec_t dr;
        crec_t cr;
        bit elig, frc, gc, gd;
        if (!rst) begin
            if (pd_v) begin
                dr.cyc = cyc; dr.miss = pd_miss; dr.data = pd_data;
                dq.push_back(dr);
                if (!pd_miss) last_disp = pd_data;
            end
            if (pc_v) begin
                cr.cyc = cyc; cr.we = pc_we; cr.data = pc_data;
                cq.push_back(cr);
                if (!pc_we) last_rd = pc_data;
            end
        end
        pd_v = 0; pc_v = 0; m_gc = 0;
        m_rdy = m_infl && !rst;
        exp_kind = 0; exp_we = 0; exp_addr = '0; exp_be = '0; exp_wdata = '0;
        if (rst) begin
            m_wait = 0; m_infl = 0; last_disp = '0; last_rd = '0;
        end else begin
            elig = cpu_req && !m_infl;
            frc  = elig && (m_wait == MW);
            gc   = frc || (elig && !disp_req);
            gd   = !gc && disp_req;
            m_infl = gc;
            if (gc || !cpu_req) m_wait = 0;
            else if (elig && gd && m_wait < MW) m_wait++;
            if (gd) begin
                exp_kind = 1; exp_addr = disp_addr;
                pd_v = 1; pd_miss = 0; pd_data = ref_mem[disp_addr];
            end else if (disp_req) begin
                pd_v = 1; pd_miss = 1; pd_data = last_disp;
            end
            if (gc) begin
                exp_kind = 2; exp_we = cpu_we; exp_addr = cpu_addr;
                exp_be = cpu_be; exp_wdata = cpu_wdata;
                m_gc = 1; pc_v = 1; pc_we = cpu_we;
                if (cpu_we) begin
                    pc_data = last_rd;
                    if (cpu_be[1]) ref_mem[cpu_addr][15:8] = cpu_wdata[15:8];
                    if (cpu_be[0]) ref_mem[cpu_addr][7:0]  = cpu_wdata[7:0];
                end else begin
                    pc_data = ref_mem[cpu_addr];
                end
            end
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        drec_t dr;
        crec_t cr;
        bit ok;
        case (exp_kind)
            1:       ok = !mem_we && mem_addr == exp_addr;
            2:       ok = mem_we == exp_we && mem_addr == exp_addr &&
                          mem_be == exp_be && mem_wdata == exp_wdata;
            default: ok = !mem_we && mem_addr == '0 && mem_be == 2'b00;
        endcase
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mem_drive cyc=%0d got we=%b addr=%h be=%b wd=%h exp kind=%0d we=%b addr=%h be=%b wd=%h",
                     cyc, mem_we, mem_addr, mem_be, mem_wdata, exp_kind, exp_we, exp_addr, exp_be, exp_wdata);
        end

        if (disp_miss) miss_count++;
        if (disp_valid || disp_miss) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL disp_spurious cyc=%0d got valid=%b miss=%b exp none", cyc, disp_valid, disp_miss);
            end else begin
                dr = dq.pop_front();
                if (dr.cyc != cyc || disp_miss != dr.miss || disp_valid == disp_miss || disp_data !== dr.data) begin
                    errors++;
                    $display("FAIL disp_out cyc=%0d got valid=%b miss=%b data=%h exp cyc=%0d miss=%b data=%h",
                             cyc, disp_valid, disp_miss, disp_data, dr.cyc, dr.miss, dr.data);
                end
            end
        end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
            dr = dq.pop_front();
            checks++; errors++;
            $display("FAIL disp_missing cyc=%0d got nothing exp miss=%b data=%h", cyc, dr.miss, dr.data);
        end

        if (cpu_ready) begin
            rdy_count++;
            checks++;
            if (cq.size() == 0) begin
                errors++;
                $display("FAIL cpu_spurious cyc=%0d got ready rdata=%h exp none", cyc, cpu_rdata);
            end else begin
                cr = cq.pop_front();
                if (cr.cyc != cyc || cpu_rdata !== cr.data) begin
                    errors++;
                    $display("FAIL cpu_out cyc=%0d got rdata=%h exp cyc=%0d we=%b rdata=%h",
                             cyc, cpu_rdata, cr.cyc, cr.we, cr.data);
                end
            end
        end else if (cq.size() > 0 && cq[0].cyc <= cyc) begin
            cr = cq.pop_front();
            checks++; errors++;
            $display("FAIL cpu_missing cyc=%0d got no ready exp rdata=%h", cyc, cr.data);
        end

        if (chk_idle) begin
            checks++;
            if (disp_valid || disp_miss || cpu_ready || disp_data !== 16'h0 || cpu_rdata !== 16'h0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got v=%b m=%b r=%b dd=%h rd=%h exp all zero",
                         cyc, disp_valid, disp_miss, cpu_ready, disp_data, cpu_rdata);
            end
        end
        if (chk_win_go) begin
            checks++;
            if (chk_win_act != chk_win_exp) begin
                errors++;
                $display("FAIL %s got %0d exp %0d", chk_win_name, chk_win_act, chk_win_exp);
            end
        end
        if (chk_end) begin
            checks++;
            if (dq.size() != 0 || cq.size() != 0) begin
                errors++;
                $display("FAIL drain got disp_left=%0d cpu_left=%0d exp 0 0", dq.size(), cq.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk_win_go = 0;
    endtask

    task automatic idle_cycle();
        tick();
        disp_req = 0; cpu_req = 0;
        model_cycle();
    endtask

    task automatic win_check(input string name, input int act, input int expv);
        chk_win_name = name; chk_win_act = act; chk_win_exp = expv; chk_win_go = 1;
    endtask

    task automatic cpu_access(input bit we, input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        int n = 0;
        do begin
            tick();
            disp_req = 0; cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_be = be;
            model_cycle();
            n++;
        end while (!m_gc && n < 300);
        tick();            // ready cycle, request still held
        model_cycle();
        tick();
        cpu_req = 0;
        model_cycle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, mbase;
        bit cpu_free;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 16'(i);

        // Reset, then idle
        rst = 1;
        for (int i = 0; i < 3; i++) begin tick(); model_cycle(); end
        tick(); rst = 0; chk_idle = 1; model_cycle();
        for (int i = 0; i < 9; i++) idle_cycle();
        tick(); chk_idle = 0; model_cycle();

        // Display stream 0..9
        for (int i = 0; i < 10; i++) begin
            tick(); disp_req = 1; disp_addr = 16'(i); cpu_req = 0; model_cycle();
        end
        idle_cycle();

        // CPU write / read / partial write / read
        cpu_access(1, 16'h1234, 16'hBEEF, 2'b11);
        cpu_access(0, 16'h1234, 16'h0000, 2'b11);
        cpu_access(1, 16'h1234, 16'h0012, 2'b01);
        cpu_access(0, 16'h1234, 16'h0000, 2'b11);
        // Display readback of the written word
        tick(); disp_req = 1; disp_addr = 16'h1234; model_cycle();
        idle_cycle();

        // Starvation guard: 4 forced slots in 68 cycles
        base = rdy_count; mbase = miss_count;
        for (int i = 0; i < 68; i++) begin
            tick();
            disp_req = 1; disp_addr = 16'($urandom_range(0, 255));
            cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
            model_cycle();
        end
        tick(); disp_req = 0; cpu_req = 0; model_cycle();
        win_check("forced_ready_count", rdy_count - base, 4);
        tick(); model_cycle();
        win_check("forced_miss_count", miss_count - mbase, 4);

        // Three back-to-back CPU reads with no display traffic
        base = rdy_count;
        for (int i = 0; i < 6; i++) begin
            tick();
            disp_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'(16'h0100 + i / 2);
            model_cycle();
        end
        tick(); cpu_req = 0; model_cycle();
        win_check("b2b_ready_count", rdy_count - base, 3);

        // Reset in the cycle after a CPU grant
        idle_cycle();
        base = rdy_count;
        tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; model_cycle();
        tick(); rst = 1; cpu_req = 0; model_cycle();
        tick(); rst = 0; model_cycle();
        tick(); model_cycle();
        win_check("reset_abandon_ready_count", rdy_count - base, 0);
        cpu_access(0, 16'h1234, 16'h0000, 2'b11);

        // Randomized traffic
        cpu_free = 1;
        for (int i = 0; i < 500; i++) begin
            tick();
            rst = ($urandom_range(0, 99) == 0);
            disp_req = ($urandom_range(0, 9) < 7);
            disp_addr = 16'($urandom_range(0, 63));
            if (cpu_free) begin
                cpu_req   = $urandom_range(0, 1) == 1;
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = 16'($urandom_range(0, 63));
                cpu_wdata = 16'($urandom);
                cpu_be    = 2'($urandom_range(0, 3));
            end
            model_cycle();
            cpu_free = rst || !cpu_req || m_rdy;
        end
        tick(); rst = 0; disp_req = 0; cpu_req = 0; model_cycle();
        for (int i = 0; i < 3; i++) idle_cycle();
        tick(); chk_end = 1; model_cycle();
        @(negedge clk);
        #1;
        chk_end = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port video RAM between the display fetch path (scan-out address generator) and the CPU bus.
- Display fetches have priority during active video. CPU accesses fill the idle slots; blanking periods are the main CPU window.
- A starvation guard forces a CPU slot after a bounded wait. The display path is told when it loses a fetch, so it can hold the previous pixel.
- Sits between the graphics fetch logic, the CPU memory interface and the VRAM macro, which has 1-cycle synchronous read latency.

Parameters:
- ADDR_W, 16, VRAM halfword address width.
- MAX_WAIT, 15, maximum number of cycles a pending CPU request is stalled by the display before a forced grant (1..255).

Ports:
- clk  in  1  system/pixel clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- disp_req  in  1  display fetch request this cycle.
- disp_addr  in  ADDR_W  display fetch halfword address.
- disp_data  out  16  fetched halfword, registered.
- disp_valid  out  1  disp_data holds the result of the previous cycle's disp_req.
- disp_miss  out  1  the previous cycle's disp_req was pre-empted by a forced CPU slot.
- cpu_req  in  1  CPU access request; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU halfword address.
- cpu_wdata  in  16  write data.
- cpu_be  in  2  byte enables [1] = bits 15:8, [0] = bits 7:0.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  16  read data, valid when cpu_ready is high after a read.
- mem_addr  out  ADDR_W  VRAM address.
- mem_we  out  1  VRAM write strobe.
- mem_be  out  2  VRAM byte enables.
- mem_wdata  out  16  VRAM write data.
- mem_rdata  in  16  VRAM read data, 1 cycle after address.

Behaviour:
- Reset values: disp_data = 0, disp_valid = 0, disp_miss = 0, cpu_ready = 0, cpu_rdata = 0. Internal: inflight = 0, wait_cnt = 0, grant_q = NONE.
- Grant is computed combinationally each cycle:
  - cpu_elig = cpu_req & ~inflight.
  - force = cpu_elig & (wait_cnt == MAX_WAIT).
  - Grant CPU if force, or if cpu_elig & ~disp_req.
  - Otherwise grant DISP if disp_req.
  - Otherwise grant NONE.
- Memory drive:
  - DISP: mem_addr = disp_addr, mem_we = 0.
  - CPU: mem_addr = cpu_addr, mem_we = cpu_we, mem_be = cpu_be, mem_wdata = cpu_wdata.
  - NONE: mem_addr = 0, mem_we = 0, mem_be = 0.
  - mem_we is never high in any other case.
- Cycle N+1 after the grant:
  - DISP granted: disp_data <= mem_rdata, disp_valid = 1.
  - CPU granted: cpu_ready = 1 for exactly one cycle. For a read, cpu_rdata = mem_rdata, held until the next read completes. For a write, cpu_rdata is unchanged.
- disp_miss = 1 in cycle N+1 when disp_req was high in N and not granted (a forced slot). disp_data holds its old value and disp_valid = 0.
- disp_valid = 0 in any cycle following a cycle without a DISP grant.
- inflight:
  - Set on a CPU grant; cleared in the cycle cpu_ready is high.
  - The CPU cannot be granted in its own ready cycle. Back-to-back CPU accesses therefore take at least 2 cycles each.
  - The requester must deassert cpu_req or present a new request in the cycle after cpu_ready.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, each cycle cpu_elig is high and DISP is granted.
  - Resets to 0 on a CPU grant or when cpu_req is low.
  - Width is 8 bits.
- CPU write latency is one cycle: the data is in VRAM when cpu_ready is seen. A display read to the same address in the next cycle returns the new data.
- Reset asserted mid-access: the in-flight CPU access is abandoned, with no cpu_ready pulse. mem_we is 0 during reset cycles. All state returns to its reset values the cycle after rst is sampled high.
- If disp_req and a forced CPU grant coincide, the CPU always wins. Only one forced slot is taken per wait episode.

Test Plan:
- Reset, then idle: all outputs at reset values, mem_we = 0 for 10 cycles.
- disp_req alone every cycle, addresses 0x0000..0x0009, RAM word = address: disp_data = 0x0000..0x0009, one cycle late, disp_valid continuously 1, disp_miss = 0.
- CPU write 0xBEEF to 0x1234 with be = 2'b11 and no display traffic:
  - mem_we high for one cycle, cpu_ready the next cycle.
  - A following CPU read of 0x1234 returns 0xBEEF.
  - Then write be = 2'b01 data 0x0012: a readback returns 0xBE12.
- Continuous disp_req with cpu_req read held, MAX_WAIT = 15:
  - CPU granted on the 16th cycle of waiting.
  - disp_miss = 1 and disp_valid = 0 in the following cycle.
  - cpu_ready pulses with the correct data.
  - The pattern repeats every 17 cycles.
- cpu_req held high for 3 consecutive accesses with disp_req = 0: cpu_ready pulses on alternate cycles, never twice in a row.
- Assert rst in the cycle after a CPU grant: no cpu_ready pulse, inflight cleared. A new request after reset completes normally.
